up_down_counter: RTL and testbench



---
 rtl/up_down_counter.sv | 34 +++
 tb/tb_up_down_counter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/up_down_counter.sv
// Synchronous WIDTH-bit up/down counter. Reset loads the start value from init,
// and after that the counter steps by one per clock in the direction given by mode.
module up_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [WIDTH-1:0] init,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Reset takes priority over counting. Both directions wrap modulo 2^WIDTH.
    always_comb begin
        count_d = count_q;
        if (rst) begin
            count_d = init;
        end else if (mode) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Table-driven bench for up_down_counter. It also runs a 256-edge round trip in
// each direction and keeps a reference value that it computes itself.
module tb_up_down_counter;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [7:0] init;
    logic [7:0] count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic       mode;
        logic [7:0] init;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    up_down_counter #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .init (init),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge. The edge after that samples them,
    // and the bench reads the output 1 time unit after that edge.
    task automatic applyStimulus(input logic r, input logic m, input logic [7:0] i);
        rst  = r;
        mode = m;
        init = i;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expected);
        checks++;
        if (count !== expected) begin
            errors++;
            $display("[TB] FAIL %s: count=%h expected=%h", name, count, expected);
        end
    endtask

    function automatic void addVec(input logic r, input logic m, input logic [7:0] i,
                                   input logic [7:0] e, input string n);
        vec_t v;
        v.rst  = r;
        v.mode = m;
        v.init = i;
        v.exp  = e;
        v.name = n;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] model;

        rst  = 1'b0;
        mode = 1'b0;
        init = 8'h00;
        #1;

        // Load 0x81 and hold reset for two edges, then count up.
        addVec(1, 1, 8'h81, 8'h81, "reset_load_edge1");
        addVec(1, 0, 8'h81, 8'h81, "reset_hold_edge2");
        addVec(0, 1, 8'h81, 8'h82, "up_82");
        addVec(0, 1, 8'h81, 8'h83, "up_83");
        addVec(0, 1, 8'h81, 8'h84, "up_84");
        // Reverse direction at 0x84.
        addVec(0, 0, 8'h81, 8'h83, "rev_83");
        addVec(0, 0, 8'h81, 8'h82, "rev_82");
        addVec(0, 0, 8'h81, 8'h81, "rev_81");
        addVec(0, 0, 8'h81, 8'h80, "rev_80");
        // Wrap upward from 0xFE.
        addVec(1, 1, 8'hFE, 8'hFE, "upwrap_load");
        addVec(0, 1, 8'hFE, 8'hFF, "upwrap_FF");
        addVec(0, 1, 8'hFE, 8'h00, "upwrap_00");
        addVec(0, 1, 8'hFE, 8'h01, "upwrap_01");
        // Wrap downward from 0x01.
        addVec(1, 0, 8'h01, 8'h01, "dnwrap_load");
        addVec(0, 0, 8'h01, 8'h00, "dnwrap_00");
        addVec(0, 0, 8'h01, 8'hFF, "dnwrap_FF");
        addVec(0, 0, 8'h01, 8'hFE, "dnwrap_FE");
        // Changing init while counting has no effect. A reset edge overrides the step.
        addVec(1, 1, 8'h90, 8'h90, "iso_load");
        addVec(0, 1, 8'h10, 8'h91, "iso_ignore_init1");
        addVec(0, 1, 8'h10, 8'h92, "iso_ignore_init2");
        addVec(1, 1, 8'h10, 8'h10, "rst_priority");
        // While reset is held, count follows init one edge later.
        addVec(1, 0, 8'h33, 8'h33, "long_rst_33");
        addVec(1, 1, 8'h44, 8'h44, "long_rst_44");
        addVec(1, 0, 8'hC7, 8'hC7, "long_rst_C7");

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].rst, vecs[k].mode, vecs[k].init);
            checkOutput(vecs[k].name, vecs[k].exp);
        end

        // Long run: load 0x81, then 256 edges up, then 256 edges down.
        applyStimulus(1'b1, 1'b1, 8'h81);
        checkOutput("long_load", 8'h81);
        model = 8'h81;
        for (int k = 1; k <= 256; k++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            model = model + 8'd1;
            if (k == 256) checkOutput("long_up_256", 8'h81);
            else if (k % 64 == 0) checkOutput("long_up_step", model);
        end
        for (int k = 1; k <= 256; k++) begin
            applyStimulus(1'b0, 1'b0, 8'hFF);
            model = model - 8'd1;
            if (k == 256) checkOutput("long_dn_256", 8'h81);
            else if (k % 64 == 0) checkOutput("long_dn_step", model);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
